// File: rtl/tsm_and_scheduler_firstorder.sv
// tsm_and_scheduler_firstorder: round-robin sharing of one first-order TSM AND gate,
// one fresh randomness word per operation, gate inputs zeroed between operations.
module tsm_and_scheduler_firstorder #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*NUM_REQ-1:0] req_share1,
    input  logic [2*NUM_REQ-1:0] req_share2,
    input  logic                 rnd_valid,
    input  logic [4:0]           rnd_data,
    output logic                 rnd_ready,
    output logic [2:0]           gate_rand_bit,
    output logic [1:0]           gate_rand_cmp,
    output logic [1:0]           gate_in_share1,
    output logic [1:0]           gate_in_share2,
    input  logic [5:0]           gate_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [5:0]           rsp_data
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, win;
    logic [1:0]      sh1_q, sh1_d, sh2_q, sh2_d;
    logic [4:0]      rnd_q, rnd_d;
    logic [5:0]      rsp_data_q, rsp_data_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            found, grant;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    // A grant needs both a requester and a fresh randomness word, so rnd is consumed 1:1 with requests.
    assign grant     = (state_q == IDLE) && found && rnd_valid;
    assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;
    assign rnd_ready = grant;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        sh1_d      = sh1_q;
        sh2_d      = sh2_q;
        rnd_d      = rnd_q;
        rsp_data_d = rsp_data_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: if (grant) begin
                state_d = ISSUE;
                rr_d    = ID_W'((int'(win) + 1) % NUM_REQ);
                id_d    = win;
                sh1_d   = req_share1[2*int'(win) +: 2];
                sh2_d   = req_share2[2*int'(win) +: 2];
                rnd_d   = rnd_data;
            end
            ISSUE: begin
                state_d = CAPTURE;
                sh1_d   = '0;
                sh2_d   = '0;
                rnd_d   = '0;
            end
            CAPTURE: begin
                state_d    = RESP;
                rsp_data_d = gate_out;
            end
            RESP: if (rsp_ready) begin
                state_d = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
                cnt_d   = 4'(FLUSH_CYCLES);
            end
            FLUSH: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q <= 4'd1) ? IDLE : FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            id_q       <= '0;
            sh1_q      <= '0;
            sh2_q      <= '0;
            rnd_q      <= '0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            sh1_q      <= sh1_d;
            sh2_q      <= sh2_d;
            rnd_q      <= rnd_d;
            rsp_data_q <= rsp_data_d;
            cnt_q      <= cnt_d;
        end
    end

    // Issue regs are non-zero only during ISSUE, so they drive the gate directly.
    assign gate_in_share1 = sh1_q;
    assign gate_in_share2 = sh2_q;
    assign gate_rand_bit  = rnd_q[2:0];
    assign gate_rand_cmp  = rnd_q[4:3];
    assign rsp_valid      = (state_q == RESP);
    assign rsp_id         = id_q;
    assign rsp_data       = rsp_data_q;
endmodule

// File: tb/tb_tsm_and_scheduler_firstorder.sv
// tb_tsm_and_scheduler_firstorder: directed bench with a behavioural first-order TSM AND gate.
module tb_tsm_and_scheduler_firstorder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid, req_ready;
    logic [7:0] req_share1, req_share2;
    logic       rnd_valid, rnd_ready;
    logic [4:0] rnd_data;
    logic [2:0] gate_rand_bit;
    logic [1:0] gate_rand_cmp, gate_in_share1, gate_in_share2;
    logic [5:0] gate_out;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_id;
    logic [5:0] rsp_data;
    int         vectors = 0;
    int         miscompares = 0;

    tsm_and_scheduler_firstorder #(.NUM_REQ(4), .ID_W(2), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_share1(req_share1), .req_share2(req_share2), .rnd_valid(rnd_valid),
        .rnd_data(rnd_data), .rnd_ready(rnd_ready), .gate_rand_bit(gate_rand_bit),
        .gate_rand_cmp(gate_rand_cmp), .gate_in_share1(gate_in_share1),
        .gate_in_share2(gate_in_share2), .gate_out(gate_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    // Gate model: shares {a,b}, randomness r = {cmp, bit}; output {ab_s2,ab_s1,a_s2,a_s1,b_s2,b_s1}.
    function automatic logic [5:0] gm(input logic [1:0] s1, input logic [1:0] s2, input logic [4:0] r);
        logic m, ab1, ab2;
        m   = ^r;
        ab1 = (s1[1] & s1[0]) ^ m;
        ab2 = (s2[1] & s2[0]) ^ (s1[1] & s2[0]) ^ (s2[1] & s1[0]) ^ m;
        return {ab2, ab1, s2[1], s1[1], s2[0], s1[0]};
    endfunction

    always @(posedge clk) gate_out <= gm(gate_in_share1, gate_in_share2, {gate_rand_cmp, gate_rand_bit});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int id, input logic [1:0] s1, input logic [1:0] s2, input logic [4:0] r);
        logic [5:0] d;
        req_share1 = 8'($urandom);
        req_share2 = 8'($urandom);
        req_share1[2*id +: 2] = s1;
        req_share2[2*id +: 2] = s2;
        req_valid = 4'(1 << id);
        rnd_valid = 1'b1;
        rnd_data  = r;
        rsp_ready = 1'b1;
        #1;
        chk("op_req_ready", 32'(req_ready), 32'(1 << id));
        chk("op_rnd_ready", 32'(rnd_ready), 32'd1);
        tick;
        req_valid = '0;
        rnd_valid = 1'b0;
        #1;
        chk("issue_gate", {gate_in_share1, gate_in_share2, gate_rand_cmp, gate_rand_bit}, {s1, s2, r});
        chk("issue_rsp_valid", 32'(rsp_valid), 32'd0);
        tick;
        #1;
        chk("capture_gate_zero", {gate_in_share1, gate_in_share2, gate_rand_cmp, gate_rand_bit}, 32'd0);
        chk("capture_rsp_valid", 32'(rsp_valid), 32'd0);
        tick;
        #1;
        d = gm(s1, s2, r);
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_id", 32'(rsp_id), 32'(id));
        chk("resp_data", 32'(rsp_data), 32'(d));
        chk("unmasked_ab", 32'(rsp_data[5] ^ rsp_data[4]), 32'((s1[1] ^ s2[1]) & (s1[0] ^ s2[0])));
        chk("unmasked_a", 32'(rsp_data[3] ^ rsp_data[2]), 32'(s1[1] ^ s2[1]));
        chk("unmasked_b", 32'(rsp_data[1] ^ rsp_data[0]), 32'(s1[0] ^ s2[0]));
        tick;
        #1;
        chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("flush_gate_zero", {gate_in_share1, gate_in_share2, gate_rand_cmp, gate_rand_bit}, 32'd0);
        tick;
    endtask

    initial begin
        int g_id[5];
        int g_cyc[5];
        int ng;
        logic [5:0] held;
        rst_n = 1'b0; req_valid = '0; req_share1 = '0; req_share2 = '0;
        rnd_valid = 1'b0; rnd_data = '0; rsp_ready = 1'b0;
        tick; tick;
        chk("rst_outputs", {req_ready, rnd_ready, rsp_valid, rsp_id, rsp_data},
            32'd0);
        chk("rst_gate", {gate_in_share1, gate_in_share2, gate_rand_cmp, gate_rand_bit}, 32'd0);
        rst_n = 1'b1;
        tick;

        // 1: a=1,b=1 on req0
        do_op(0, 2'b11, 2'b00, 5'b10110);

        // 2: all requesters valid, grant order from a fresh pointer
        rst_n = 1'b0; tick; rst_n = 1'b1;
        req_valid = 4'hF; rnd_valid = 1'b1; rnd_data = 5'b01101; rsp_ready = 1'b1;
        req_share1 = 8'hA5; req_share2 = 8'h3C;
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            #1;
            chk("pair_rnd_req", 32'(rnd_ready), 32'(req_ready != 0));
            chk("onehot0_ready", 32'($onehot0(req_ready)), 32'd1);
            if (rnd_ready) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) g_id[ng] = i;
                g_cyc[ng] = c;
                ng++;
            end
            tick;
        end
        req_valid = '0; rnd_valid = 1'b0;
        chk("grant_count", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < ng) chk("grant_order", 32'(g_id[i]), 32'(i % 4));
            if (i > 0 && i < ng) chk("grant_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd5);
        end
        repeat (8) tick;

        // 3: request without randomness is held off
        req_share1 = 8'b0000_1000; req_share2 = 8'b0000_0100;
        req_valid = 4'b0010; rnd_valid = 1'b0; rsp_ready = 1'b0; rnd_data = 5'b11001;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("norand_ready", {req_ready, rnd_ready}, 32'd0);
            chk("norand_gate", {gate_in_share1, gate_in_share2, gate_rand_cmp, gate_rand_bit}, 32'd0);
            tick;
        end
        rnd_valid = 1'b1;
        #1;
        chk("rand_arrives_grant", {req_ready, rnd_ready}, {4'b0010, 1'b1});

        // 4: backpressure on the response
        tick;
        req_valid = 4'b0001; rnd_data = 5'b00011;
        tick; tick;
        held = gm(2'b10, 2'b01, 5'b11001);
        chk("bp_first_valid", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd1, held});
        for (int c = 0; c < 6; c++) begin
            tick;
            chk("bp_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd1, held});
            chk("bp_no_grant", {req_ready, rnd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick;
        chk("bp_flush", {rsp_valid, req_ready, rnd_ready}, 32'd0);
        tick;
        chk("bp_idle_grant", {req_ready, rnd_ready}, {4'b0001, 1'b1});

        // 5: reset during CAPTURE drops the op and clears the pointer
        tick;
        req_valid = '0; rnd_valid = 1'b0;
        tick;
        rst_n = 1'b0;
        tick;
        chk("midrst_outputs", {req_ready, rnd_ready, rsp_valid, rsp_id, rsp_data}, 32'd0);
        chk("midrst_gate", {gate_in_share1, gate_in_share2, gate_rand_cmp, gate_rand_bit}, 32'd0);
        rst_n = 1'b1;
        tick;
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        req_valid = 4'b0011; rnd_valid = 1'b1;
        #1;
        chk("midrst_rr_zero", 32'(req_ready), 32'b0001);
        req_valid = '0; rnd_valid = 1'b0;
        tick;

        // 6: every share combination with random randomness
        for (int i = 0; i < 1000; i++)
            do_op(i % 4, 2'(i), 2'(i >> 2), 5'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
